// File: rtl/reg_file_rename_if.sv
// Bundle of the issue-side and CDB-side signals of the tagged rename register file.
// master = decode/issue + CDB arbiter side, slave = the register file.
interface reg_file_rename_if #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned NREG  = 32,
  parameter int unsigned RW    = $clog2(NREG),
  parameter int unsigned TAG_W = 4,
  parameter int unsigned NRD   = 2,
  parameter int unsigned NWB   = 2
);
  localparam int unsigned CW = $clog2(NREG + 1);

  logic [NWB-1:0]            wb_vld;
  logic [NWB-1:0][RW-1:0]    wb_reg;
  logic [NWB-1:0][TAG_W-1:0] wb_tag;
  logic [NWB-1:0][XLEN-1:0]  wb_data;
  logic [NRD-1:0]            rd_ce;
  logic [NRD-1:0][RW-1:0]    rs;
  logic                      ren_ce;
  logic [RW-1:0]             ren_reg;
  logic [TAG_W-1:0]          ren_tag;
  logic [NRD-1:0][TAG_W-1:0] src_tag;
  logic [NRD-1:0][XLEN-1:0]  src_data;
  logic [CW-1:0]             busy_cnt;

  modport master (
    output wb_vld, wb_reg, wb_tag, wb_data, rd_ce, rs, ren_ce, ren_reg, ren_tag,
    input  src_tag, src_data, busy_cnt
  );

  modport slave (
    input  wb_vld, wb_reg, wb_tag, wb_data, rd_ce, rs, ren_ce, ren_reg, ren_tag,
    output src_tag, src_data, busy_cnt
  );
endinterface

// File: rtl/reg_file_rename.sv
// Tagged architectural register file with NRD registered read ports, NWB CDB write-back
// channels and one rename port. Define REG_FILE_BYPASS_EN to forward same-cycle CDB hits to reads.
module reg_file_rename #(
  parameter int unsigned      XLEN        = 32,
  parameter int unsigned      NREG        = 32,
  parameter int unsigned      RW          = $clog2(NREG),
  parameter int unsigned      TAG_W       = 4,
  parameter logic [TAG_W-1:0] TAG_INVALID = '0,
  parameter int unsigned      NRD         = 2,
  parameter int unsigned      NWB         = 2
) (
  input logic           clk,
  input logic           rst,
  input logic           rst_tag,
  reg_file_rename_if.slave bus
);
  localparam int unsigned CW = $clog2(NREG + 1);

  logic [XLEN-1:0]           data_q [NREG];
  logic [TAG_W-1:0]          tag_q  [NREG];
  logic [NREG-1:0]           wb_hit;
  logic [XLEN-1:0]           wb_val [NREG];
  logic [NREG-1:0]           ren_hit;
  logic                      busy_inc;
  logic [CW-1:0]             busy_dec;
  logic [CW-1:0]             busy_nxt;
  logic [CW-1:0]             busy_q;
  logic [NRD-1:0][TAG_W-1:0] src_tag_q;
  logic [NRD-1:0][XLEN-1:0]  src_data_q;
  logic [NRD-1:0][TAG_W-1:0] rd_tag_nxt;
  logic [NRD-1:0][XLEN-1:0]  rd_data_nxt;

  // Per-register CDB match; channels scanned high to low so the lowest channel wins.
  always_comb begin
    wb_hit  = '0;
    ren_hit = '0;
    for (int unsigned r = 0; r < NREG; r++) wb_val[r] = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      ren_hit[r] = bus.ren_ce && (bus.ren_reg == RW'(r));
      for (int unsigned k = NWB; k > 0; k--) begin
        if (bus.wb_vld[k-1] && (bus.wb_reg[k-1] == RW'(r)) && (bus.wb_tag[k-1] == tag_q[r])) begin
          wb_hit[r] = 1'b1;
          wb_val[r] = bus.wb_data[k-1];
        end
      end
    end
  end

  // A rename landing on a register being written back keeps it busy, so no decrement.
  always_comb begin
    busy_inc = bus.ren_ce && (bus.ren_reg != '0) && (tag_q[bus.ren_reg] == TAG_INVALID);
    busy_dec = '0;
    for (int unsigned r = 1; r < NREG; r++) begin
      if (wb_hit[r] && !ren_hit[r] && (tag_q[r] != TAG_INVALID)) busy_dec = busy_dec + CW'(1);
    end
    busy_nxt = busy_q + CW'(busy_inc) - busy_dec;
  end

  always_comb begin
    for (int unsigned p = 0; p < NRD; p++) begin
      rd_tag_nxt[p]  = TAG_INVALID;
      rd_data_nxt[p] = src_data_q[p];
      if (bus.rd_ce[p]) begin
        if (bus.rs[p] == '0) begin
          rd_data_nxt[p] = '0;
        end else begin
          rd_tag_nxt[p]  = tag_q[bus.rs[p]];
          rd_data_nxt[p] = data_q[bus.rs[p]];
`ifdef REG_FILE_BYPASS_EN
          if (wb_hit[bus.rs[p]]) begin
            rd_tag_nxt[p]  = TAG_INVALID;
            rd_data_nxt[p] = wb_val[bus.rs[p]];
          end
`endif
        end
      end
    end
  end

  // Tags follow both resets; rename takes priority over a clearing write-back.
  always_ff @(posedge clk or posedge rst or posedge rst_tag) begin
    if (rst || rst_tag) begin
      for (int unsigned r = 0; r < NREG; r++) tag_q[r] <= TAG_INVALID;
    end else begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (ren_hit[r])     tag_q[r] <= bus.ren_tag;
        else if (wb_hit[r]) tag_q[r] <= TAG_INVALID;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned r = 0; r < NREG; r++) data_q[r] <= '0;
    end else if (!rst_tag) begin
      for (int unsigned r = 1; r < NREG; r++) begin
        if (wb_hit[r]) data_q[r] <= wb_val[r];
      end
    end
  end

  always_ff @(posedge clk or posedge rst or posedge rst_tag) begin
    if (rst || rst_tag) busy_q <= '0;
    else                busy_q <= busy_nxt;
  end

  always_ff @(posedge clk or posedge rst or posedge rst_tag) begin
    if (rst || rst_tag) src_tag_q <= {NRD{TAG_INVALID}};
    else                src_tag_q <= rd_tag_nxt;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) src_data_q <= '0;
    else     src_data_q <= rd_data_nxt;
  end

  assign bus.src_tag  = src_tag_q;
  assign bus.src_data = src_data_q;
  assign bus.busy_cnt = busy_q;
endmodule

// File: tb/tb_reg_file_rename.sv
// Randomized and directed self-checking bench for reg_file_rename against a behavioural model.
module tb_reg_file_rename;
  logic clk;
  logic rst;
  logic rst_tag;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] m_data [32];
  logic [3:0]  m_tag  [32];
  logic [3:0]  m_stag [2];
  logic [31:0] m_sdata[2];

  reg_file_rename_if #(.XLEN(32), .NREG(32), .RW(5), .TAG_W(4), .NRD(2), .NWB(2)) bus ();

  reg_file_rename #(
    .XLEN(32), .NREG(32), .RW(5), .TAG_W(4), .TAG_INVALID(4'd0), .NRD(2), .NWB(2)
  ) dut (
    .clk(clk), .rst(rst), .rst_tag(rst_tag), .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h t=%0t", name, got, exp, $time);
    end
  endtask

  task automatic set_idle();
    bus.wb_vld  = '0;
    bus.wb_reg  = '0;
    bus.wb_tag  = '0;
    bus.wb_data = '0;
    bus.rd_ce   = '0;
    bus.rs      = '0;
    bus.ren_ce  = 1'b0;
    bus.ren_reg = '0;
    bus.ren_tag = '0;
  endtask

  function automatic int busy_model();
    int n = 0;
    for (int r = 0; r < 32; r++) if (m_tag[r] != 4'd0) n++;
    return n;
  endfunction

  // Model update from the pre-edge state and current inputs, then clock and compare.
  task automatic step();
    bit done [32];
    for (int r = 0; r < 32; r++) done[r] = 1'b0;
    for (int p = 0; p < 2; p++) begin
      int s = int'(bus.rs[p]);
      if (!bus.rd_ce[p]) begin
        m_stag[p] = 4'd0;
      end else if (s == 0) begin
        m_stag[p] = 4'd0;
        m_sdata[p] = 32'd0;
      end else begin
        m_stag[p] = m_tag[s];
        m_sdata[p] = m_data[s];
`ifdef REG_FILE_BYPASS_EN
        for (int k = 1; k >= 0; k--) begin
          if (bus.wb_vld[k] && int'(bus.wb_reg[k]) == s && bus.wb_tag[k] == m_tag[s]) begin
            m_stag[p] = 4'd0;
            m_sdata[p] = bus.wb_data[k];
          end
        end
`endif
      end
    end
    for (int k = 0; k < 2; k++) begin
      int r = int'(bus.wb_reg[k]);
      if (bus.wb_vld[k] && r != 0 && !done[r] && m_tag[r] == bus.wb_tag[k]) begin
        m_data[r] = bus.wb_data[k];
        m_tag[r] = 4'd0;
        done[r] = 1'b1;
      end
    end
    if (bus.ren_ce && bus.ren_reg != 5'd0) m_tag[int'(bus.ren_reg)] = bus.ren_tag;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      check($sformatf("src_tag%0d", p), 32'(bus.src_tag[p]), 32'(m_stag[p]));
      check($sformatf("src_data%0d", p), bus.src_data[p], m_sdata[p]);
    end
    check("busy_cnt", 32'(bus.busy_cnt), 32'(busy_model()));
    set_idle();
  endtask

  // Asynchronous branch flush between clock edges.
  task automatic pulse_rst_tag();
    #3 rst_tag = 1'b1;
    #2;
    check("flush_busy", 32'(bus.busy_cnt), 32'd0);
    check("flush_tag0", 32'(bus.src_tag[0]), 32'd0);
    check("flush_tag1", 32'(bus.src_tag[1]), 32'd0);
    for (int r = 0; r < 32; r++) m_tag[r] = 4'd0;
    for (int p = 0; p < 2; p++) m_stag[p] = 4'd0;
    #1 rst_tag = 1'b0;
  endtask

  task automatic rename(input int r, input int t);
    bus.ren_ce = 1'b1;
    bus.ren_reg = 5'(r);
    bus.ren_tag = 4'(t);
  endtask

  task automatic wb(input int k, input int r, input int t, input logic [31:0] d);
    bus.wb_vld[k] = 1'b1;
    bus.wb_reg[k] = 5'(r);
    bus.wb_tag[k] = 4'(t);
    bus.wb_data[k] = d;
  endtask

  task automatic rd(input int p, input int r);
    bus.rd_ce[p] = 1'b1;
    bus.rs[p] = 5'(r);
  endtask

  initial begin
    rst = 1'b1;
    rst_tag = 1'b0;
    set_idle();
    for (int r = 0; r < 32; r++) begin
      m_data[r] = '0;
      m_tag[r] = '0;
    end
    for (int p = 0; p < 2; p++) begin
      m_stag[p] = '0;
      m_sdata[p] = '0;
    end
    #12;
    check("rst_tag0", 32'(bus.src_tag[0]), 32'd0);
    check("rst_data0", bus.src_data[0], 32'd0);
    check("rst_busy", 32'(bus.busy_cnt), 32'd0);
    rst = 1'b0;

    rd(0, 5); rd(1, 5); step();
    check("r5_tag", 32'(bus.src_tag[1]), 32'd0);

    rename(3, 7); step();
    rd(0, 3); step();
    check("ren_tag7", 32'(bus.src_tag[0]), 32'd7);
    check("ren_busy1", 32'(bus.busy_cnt), 32'd1);
    wb(0, 3, 7, 32'hDEADBEEF); step();
    rd(0, 3); step();
    check("wb_tag0", 32'(bus.src_tag[0]), 32'd0);
    check("wb_data", bus.src_data[0], 32'hDEADBEEF);
    check("wb_busy0", 32'(bus.busy_cnt), 32'd0);

    rename(3, 7); step();
    rename(3, 9); step();
    wb(1, 3, 7, 32'h11); step();
    rd(0, 3); step();
    check("stale_tag", 32'(bus.src_tag[0]), 32'd9);
    check("stale_data", bus.src_data[0], 32'hDEADBEEF);
    check("stale_busy", 32'(bus.busy_cnt), 32'd1);

    rename(4, 1); step();
    wb(0, 4, 1, 32'h55); step();
    rename(4, 2); rd(0, 4); step();
    check("self_tag", 32'(bus.src_tag[0]), 32'd0);
    check("self_data", bus.src_data[0], 32'h55);
    rd(0, 4); step();
    check("self_next", 32'(bus.src_tag[0]), 32'd2);

    rename(6, 5); step();
    rd(1, 6); wb(0, 6, 5, 32'hA5); step();
`ifdef REG_FILE_BYPASS_EN
    check("byp_tag", 32'(bus.src_tag[1]), 32'd0);
    check("byp_data", bus.src_data[1], 32'hA5);
`else
    check("nobyp_tag", 32'(bus.src_tag[1]), 32'd5);
    check("nobyp_data", bus.src_data[1], 32'd0);
`endif

    // Rename+matching write-back on the same register: data from CDB, tag from rename.
    wb(0, 4, 2, 32'h77); rename(4, 12); step();
    rd(0, 4); step();
    check("both_tag", 32'(bus.src_tag[0]), 32'd12);
    check("both_data", bus.src_data[0], 32'h77);

    rename(1, 3); step();
    rename(2, 4); step();
    rename(7, 6); rd(0, 7); step();
    pulse_rst_tag();
    wb(0, 1, 3, 32'hBAD1); wb(1, 7, 6, 32'hBAD7); step();
    rd(0, 1); rd(1, 3); step();
    check("flush_r1", bus.src_data[0], 32'd0);
    check("flush_r3", bus.src_data[1], 32'hDEADBEEF);

    for (int n = 0; n < 400; n++) begin
      for (int k = 0; k < 2; k++) begin
        int r = $urandom_range(0, 7);
        bus.wb_vld[k] = ($urandom_range(0, 2) != 0);
        bus.wb_reg[k] = 5'(r);
        if (m_tag[r] != 4'd0 && $urandom_range(0, 3) != 0) bus.wb_tag[k] = m_tag[r];
        else bus.wb_tag[k] = 4'($urandom_range(1, 15));
        bus.wb_data[k] = $urandom;
      end
      for (int p = 0; p < 2; p++) begin
        bus.rd_ce[p] = ($urandom_range(0, 3) != 0);
        bus.rs[p] = 5'($urandom_range(0, 7));
      end
      bus.ren_ce = ($urandom_range(0, 1) != 0);
      bus.ren_reg = 5'($urandom_range(0, 7));
      bus.ren_tag = 4'($urandom_range(1, 15));
      step();
      if ($urandom_range(0, 63) == 0) pulse_rst_tag();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/reg_file_rename.md
# reg_file_rename

Parametrised tagged architectural register file for the Tomasulo issue stage: the successor to the fixed 2-read/1-write tagged register file. It holds NREG registers of XLEN data plus a rename tag per register. It offers NRD registered read ports, NWB common-data-bus (CDB) write-back channels and one rename port. An optional CDB-to-read bypass is included, along with a live count of renamed (busy) registers. It sits between decode/issue, which reads sources and renames the destination, and the CDB arbiter, which writes results back.

## Interface
- XLEN, 32, data width.
- NREG, 32, register count; register 0 is hard-wired zero and never renamed.
- RW, $clog2(NREG), register-number width.
- TAG_W, 4, tag width.
- TAG_INVALID, 0, tag value meaning "data valid, not renamed".
- NRD, 2, number of read ports.
- NWB, 2, number of CDB write-back channels.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous, active-high; clears all data, tags, outputs and busy_cnt.
- rst_tag  in  1  reset rst_tag, asynchronous, active-high; clears every tag to TAG_INVALID (branch flush), data kept.
- wb_vld  in  NWB  per-channel write-back valid.
- wb_reg  in  NWB×RW  destination register per channel.
- wb_tag  in  NWB×TAG_W  producing tag per channel.
- wb_data  in  NWB×XLEN  result per channel.
- rd_ce  in  NRD  read enable per port.
- rs  in  NRD×RW  source register per port.
- ren_ce  in  1  rename enable.
- ren_reg  in  RW  register to rename.
- ren_tag  in  TAG_W  new tag.
- src_tag  out  NRD×TAG_W  registered tag per port.
- src_data  out  NRD×XLEN  registered data per port.
- busy_cnt  out  $clog2(NREG+1)  number of registers whose tag ≠ TAG_INVALID.

## Operation
- All state updates occur on the rising clk edge unless rst or rst_tag is asserted.
- Write-back, per channel k: if wb_vld[k] and regs[wb_reg[k]].tag == wb_tag[k] and wb_reg[k] ≠ 0, then data ← wb_data[k] and tag ← TAG_INVALID. A tag mismatch means the result is stale and the write is dropped entirely.
- Two channels hitting the same register with a matching tag is an illegal condition, since tags are unique. The lowest k wins deterministically.
- Rename: if ren_ce and ren_reg ≠ 0, then tag ← ren_tag.
- Rename and a matching write-back to the same register in the same cycle: data takes wb_data and tag takes ren_tag. Rename wins the tag.
- Read, per port p with rd_ce[p]=1:
  - src_tag/src_data are loaded from the pre-edge state of regs[rs[p]].
  - A rename in the same cycle is not visible, so an instruction reading its own destination gets the old mapping.
  - rs=0 always returns tag TAG_INVALID and data 0.
- Read with rd_ce[p]=0: src_tag[p] ← TAG_INVALID and src_data[p] holds.
- busy_cnt:
  - Recomputed each edge as +1 for a rename of a non-busy register.
  - −1 for each write-back that clears a tag, except when a rename to the same register in that cycle keeps it busy.
  - A rename of an already-busy register leaves the count unchanged.
  - The count never exceeds NREG−1.
- rst_tag: while high, all tags read TAG_INVALID, busy_cnt=0 and src_tag outputs are forced to TAG_INVALID. Renames and write-backs are ignored; data is unaffected.

## Timing
- Read latency is 1 cycle: address at edge n, outputs valid after edge n.
- A write-back at edge n is visible to a read sampled at edge n+1. With bypass, it is also visible at edge n (see Configuration).
- Reset values of all outputs are src_tag=TAG_INVALID, src_data=0 and busy_cnt=0.
- On rst: all registers are set to data 0 and TAG_INVALID.
- Release of rst or rst_tag is synchronised externally. The first edge after deassertion operates normally.

## Configuration
- REG_FILE_BYPASS_EN defined:
  - A read port whose source tag matches a same-cycle valid write-back (same register, same tag) returns wb_data and TAG_INVALID.
  - Lowest channel wins.
- REG_FILE_BYPASS_EN undefined:
  - Reads return the pre-edge stored tag/data with no bypass.
  - Consumers must snoop the CDB for the returned tag.

## Test plan
- Reset then read r5 on both ports -> src_tag=0, src_data=0, busy_cnt=0.
- Rename r3→tag 7, then next cycle wb(r3, tag 7, 0xDEADBEEF), then read r3 -> first read after rename gives tag 7 and busy_cnt=1; read after write-back gives tag 0, data 0xDEADBEEF, busy_cnt=0.
- Rename r3→7, rename r3→9, then wb(r3, 7, 0x11) -> write dropped, tag stays 9, busy_cnt=1.
- Same cycle: rename r4→2 and read r4 on port 0, r4 previously tag 0 with data 0x55 -> port 0 returns tag 0, data 0x55; the following read returns tag 2.
- Bypass (macro on): r6 tag 5; in the same cycle read r6 and wb(r6, 5, 0xA5) -> tag 0, data 0xA5. With the macro off -> tag 5, old data.
- Rename r1, r2, r7; pulse rst_tag mid-cycle -> all tags 0 immediately, busy_cnt=0, data unchanged; a following wb with old tags is dropped.
